int_reg_bank: RTL and testbench

Register bank that sits directly downstream of the AXI4-Lite-to-internal bridge and terminates its internal interface. It decodes `int_addr` into `NUM_REGS` word-aligned slots, holds byte-strobed control registers, samples status inputs for read-only slots, and returns single-cycle write and read acknowledges. It also produces per-register write and read pulses for side effects in the user logic.

---
 rtl/int_reg_pkg.sv | 16 +
 rtl/int_reg_cell.sv | 30 +++
 rtl/int_reg_bank.sv | 129 ++++++++++++
 tb/tb_int_reg_bank.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/int_reg_pkg.sv
// Shared constants and helpers for the internal register bank.
package int_reg_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    function automatic int unsigned byte_lanes(input int unsigned data_width);
        return data_width / 8;
    endfunction

    // Byte-address bits below the word index.
    function automatic int unsigned addr_shift(input int unsigned data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/int_reg_cell.sv
// Single control register with per-byte-lane strobed write and loadable reset value.
module int_reg_cell
    import int_reg_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                             aclk,
    input  logic                             areset,
    input  logic [DATA_WIDTH-1:0]            reset_value,
    input  logic                             wr_en,
    input  logic [DATA_WIDTH-1:0]            wr_data,
    input  logic [byte_lanes(DATA_WIDTH)-1:0] wr_strb,
    output logic [DATA_WIDTH-1:0]            q
);

    localparam int unsigned LANES = byte_lanes(DATA_WIDTH);

    always_ff @(posedge aclk) begin
        if (areset) begin
            q <= reset_value;
        end else if (wr_en) begin
            for (int unsigned b = 0; b < LANES; b++) begin
                if (wr_strb[b]) begin
                    q[b*8 +: 8] <= wr_data[b*8 +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/int_reg_bank.sv
// Register bank terminating the bridge's internal interface; single-cycle acks.
// Optional feature: define INT_REG_BANK_ERR_EN to report RO/out-of-range accesses as errors.
module int_reg_bank
    import int_reg_pkg::*;
#(
    parameter int unsigned                     ADDR_WIDTH  = 10,
    parameter int unsigned                     DATA_WIDTH  = 32,
    parameter int unsigned                     NUM_REGS    = 16,
    parameter logic [NUM_REGS-1:0]             RO_MASK     = '0,
    parameter logic [NUM_REGS*DATA_WIDTH-1:0]  RESET_VALUE = '0
) (
    input  logic                              aclk,
    input  logic                              areset,
    input  logic [ADDR_WIDTH-1:0]             int_addr,
    input  logic [DATA_WIDTH-1:0]             int_wr_data,
    input  logic [DATA_WIDTH/8-1:0]           int_wr_strb,
    input  logic                              int_wr_en,
    input  logic                              int_rd_en,
    output logic                              int_wr_ack,
    output logic                              int_wr_err,
    output logic                              int_rd_ack,
    output logic                              int_rd_err,
    output logic [DATA_WIDTH-1:0]             int_rd_data,
    output logic [NUM_REGS*DATA_WIDTH-1:0]    ctrl_regs,
    input  logic [NUM_REGS*DATA_WIDTH-1:0]    stat_regs,
    output logic [NUM_REGS-1:0]               wr_pulse,
    output logic [NUM_REGS-1:0]               rd_pulse
);

    localparam int unsigned SHIFT = addr_shift(DATA_WIDTH);
    localparam int unsigned IDX_W = ADDR_WIDTH - SHIFT;

    logic [IDX_W-1:0]      idx;
    logic                  rd_req;
    logic [NUM_REGS-1:0]   wr_hit;
    logic [NUM_REGS-1:0]   rd_hit;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  unused_bits;

    assign idx    = int_addr[ADDR_WIDTH-1:SHIFT];
    // A write wins over a simultaneous (illegal) read.
    assign rd_req = int_rd_en && !int_wr_en;

    assign unused_bits = &{1'b0, int_addr[SHIFT-1:0], stat_regs};

    // Out-of-range indices match no slot, so they fall through to no hit and zero data.
    always_comb begin
        wr_hit  = '0;
        rd_hit  = '0;
        rd_word = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (idx == IDX_W'(i)) begin
                wr_hit[i] = int_wr_en && !RO_MASK[i];
                rd_hit[i] = rd_req;
                rd_word   = RO_MASK[i] ? stat_regs[i*DATA_WIDTH +: DATA_WIDTH]
                                       : ctrl_regs[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_slot
        if (RO_MASK[g]) begin : g_ro
            assign ctrl_regs[g*DATA_WIDTH +: DATA_WIDTH] = '0;
        end else begin : g_rw
            int_reg_cell #(
                .DATA_WIDTH (DATA_WIDTH)
            ) u_cell (
                .aclk        (aclk),
                .areset      (areset),
                .reset_value (RESET_VALUE[g*DATA_WIDTH +: DATA_WIDTH]),
                .wr_en       (wr_hit[g]),
                .wr_data     (int_wr_data),
                .wr_strb     (int_wr_strb),
                .q           (ctrl_regs[g*DATA_WIDTH +: DATA_WIDTH])
            );
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            int_wr_ack  <= 1'b0;
            int_rd_ack  <= 1'b0;
            wr_pulse    <= '0;
            rd_pulse    <= '0;
            int_rd_data <= '0;
        end else begin
            int_wr_ack <= int_wr_en;
            int_rd_ack <= rd_req;
            wr_pulse   <= wr_hit;
            rd_pulse   <= rd_hit;
            if (rd_req) begin
                int_rd_data <= rd_word;
            end
        end
    end

`ifdef INT_REG_BANK_ERR_EN
    logic in_range;
    logic ro_sel;

    assign in_range = (32'(idx) < NUM_REGS);
    assign ro_sel   = |(RO_MASK & rd_hit_any_mask(idx));

    function automatic logic [NUM_REGS-1:0] rd_hit_any_mask(input logic [IDX_W-1:0] sel);
        logic [NUM_REGS-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (sel == IDX_W'(i)) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

    always_ff @(posedge aclk) begin
        if (areset) begin
            int_wr_err <= 1'b0;
            int_rd_err <= 1'b0;
        end else begin
            int_wr_err <= int_wr_en && (!in_range || ro_sel);
            int_rd_err <= rd_req && !in_range;
        end
    end
`else
    assign int_wr_err = 1'b0;
    assign int_rd_err = 1'b0;
`endif

endmodule

// File: tb/tb_int_reg_bank.sv
// Directed, table-driven checks of int_reg_bank plus multi-cycle corner sequences.
module tb_int_reg_bank;

    localparam int unsigned AW = 10;
    localparam int unsigned DW = 32;
    localparam int unsigned NR = 16;
    localparam logic [NR-1:0] RO = 16'h0004;
    localparam logic [NR*DW-1:0] RV = (512'hDEADBEEF << (5*32)) | 512'h12345678;
`ifdef INT_REG_BANK_ERR_EN
    localparam logic E = 1'b1;
`else
    localparam logic E = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            areset;
    logic [AW-1:0]   int_addr;
    logic [DW-1:0]   int_wr_data;
    logic [DW/8-1:0] int_wr_strb;
    logic            int_wr_en;
    logic            int_rd_en;
    logic            int_wr_ack;
    logic            int_wr_err;
    logic            int_rd_ack;
    logic            int_rd_err;
    logic [DW-1:0]   int_rd_data;
    logic [NR*DW-1:0] ctrl_regs;
    logic [NR*DW-1:0] stat_regs;
    logic [NR-1:0]   wr_pulse;
    logic [NR-1:0]   rd_pulse;

    int tests  = 0;
    int errors = 0;

    always #5 clk = ~clk;

    int_reg_bank #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .NUM_REGS    (NR),
        .RO_MASK     (RO),
        .RESET_VALUE (RV)
    ) dut (
        .aclk        (clk),
        .areset      (areset),
        .int_addr    (int_addr),
        .int_wr_data (int_wr_data),
        .int_wr_strb (int_wr_strb),
        .int_wr_en   (int_wr_en),
        .int_rd_en   (int_rd_en),
        .int_wr_ack  (int_wr_ack),
        .int_wr_err  (int_wr_err),
        .int_rd_ack  (int_rd_ack),
        .int_rd_err  (int_rd_err),
        .int_rd_data (int_rd_data),
        .ctrl_regs   (ctrl_regs),
        .stat_regs   (stat_regs),
        .wr_pulse    (wr_pulse),
        .rd_pulse    (rd_pulse)
    );

    // The bridge must never issue a read and a write together.
    always @(posedge clk) begin
        if (!areset) begin
            assert (!(int_wr_en && int_rd_en)) else $error("illegal simultaneous wr/rd request");
        end
    end

    typedef struct {
        string         name;
        logic          wr;
        logic          rd;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [3:0]    strb;
        logic          wr_err;
        logic          rd_err;
        logic [DW-1:0] rd_data;
        logic [NR-1:0] wr_pls;
        logic [NR-1:0] rd_pls;
        int            slot;
        logic [DW-1:0] slot_val;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        int_wr_en   = 1'b0;
        int_rd_en   = 1'b0;
        int_addr    = '0;
        int_wr_data = '0;
        int_wr_strb = '0;
    endtask

    initial begin
        for (int i = 0; i < NR; i++) stat_regs[i*DW +: DW] = 32'hA5A50000 | 32'(i);
        stat_regs[2*DW +: DW] = 32'hCAFE0001;
        idle_inputs();
        areset = 1'b1;

        //        name          wr    rd    addr     data          strb     werr  rerr  rdata         wpls      rpls    slot val
        vecs[0]  = '{"wr_s1_0101", 1'b1, 1'b0, 10'h004, 32'hAABBCCDD, 4'b0101, 1'b0, 1'b0, 32'h0,        16'h0002, 16'h0, 1, 32'h00BB00DD};
        vecs[1]  = '{"wr_s1_1010", 1'b1, 1'b0, 10'h004, 32'h11223344, 4'b1010, 1'b0, 1'b0, 32'h0,        16'h0002, 16'h0, 1, 32'h11BB33DD};
        vecs[2]  = '{"wr_s5_nostrb",1'b1,1'b0, 10'h014, 32'h01020304, 4'b0000, 1'b0, 1'b0, 32'h0,        16'h0020, 16'h0, 5, 32'hDEADBEEF};
        vecs[3]  = '{"rd_s1",      1'b0, 1'b1, 10'h004, 32'h0,        4'b0000, 1'b0, 1'b0, 32'h11BB33DD, 16'h0,    16'h0002, 1, 32'h11BB33DD};
        vecs[4]  = '{"rd_ro_s2",   1'b0, 1'b1, 10'h008, 32'h0,        4'b0000, 1'b0, 1'b0, 32'hCAFE0001, 16'h0,    16'h0004, 2, 32'h0};
        vecs[5]  = '{"rd_s2_lowbits",1'b0,1'b1,10'h00B, 32'h0,        4'b0000, 1'b0, 1'b0, 32'hCAFE0001, 16'h0,    16'h0004, 2, 32'h0};
        vecs[6]  = '{"wr_oor",     1'b1, 1'b0, 10'h040, 32'hFFFFFFFF, 4'b1111, E,    1'b0, 32'h0,        16'h0,    16'h0, 0, 32'h12345678};
        vecs[7]  = '{"wr_ro_s2",   1'b1, 1'b0, 10'h008, 32'hFFFFFFFF, 4'b1111, E,    1'b0, 32'h0,        16'h0,    16'h0, 2, 32'h0};
        vecs[8]  = '{"rd_oor",     1'b0, 1'b1, 10'h040, 32'h0,        4'b0000, 1'b0, E,    32'h0,        16'h0,    16'h0, 0, 32'h12345678};
        vecs[9]  = '{"wr_s15",     1'b1, 1'b0, 10'h03C, 32'hFFFFFFFF, 4'b1111, 1'b0, 1'b0, 32'h0,        16'h8000, 16'h0, 15, 32'hFFFFFFFF};
        vecs[10] = '{"rd_s15",     1'b0, 1'b1, 10'h03C, 32'h0,        4'b0000, 1'b0, 1'b0, 32'hFFFFFFFF, 16'h0,    16'h8000, 15, 32'hFFFFFFFF};
        vecs[11] = '{"rd_top_oor", 1'b0, 1'b1, 10'h3FC, 32'h0,        4'b0000, 1'b0, E,    32'h0,        16'h0,    16'h0, 0, 32'h12345678};

        repeat (3) @(negedge clk);
        areset = 1'b0;
        @(negedge clk);
        check("rst_slot0",   64'(ctrl_regs[31:0]), 64'h12345678);
        check("rst_slot5",   64'(ctrl_regs[5*DW +: DW]), 64'hDEADBEEF);
        check("rst_acks",    64'({int_wr_ack, int_rd_ack, int_wr_err, int_rd_err}), 64'h0);
        check("rst_pulses",  64'({wr_pulse, rd_pulse}), 64'h0);
        check("rst_rd_data", 64'(int_rd_data), 64'h0);

        foreach (vecs[k]) begin
            int_wr_en   = vecs[k].wr;
            int_rd_en   = vecs[k].rd;
            int_addr    = vecs[k].addr;
            int_wr_data = vecs[k].data;
            int_wr_strb = vecs[k].strb;
            @(negedge clk);
            idle_inputs();
            check({vecs[k].name, ".wr_ack"}, 64'(int_wr_ack), 64'(vecs[k].wr));
            check({vecs[k].name, ".rd_ack"}, 64'(int_rd_ack), 64'(vecs[k].rd));
            check({vecs[k].name, ".wr_err"}, 64'(int_wr_err), 64'(vecs[k].wr_err));
            check({vecs[k].name, ".rd_err"}, 64'(int_rd_err), 64'(vecs[k].rd_err));
            check({vecs[k].name, ".wr_pulse"}, 64'(wr_pulse), 64'(vecs[k].wr_pls));
            check({vecs[k].name, ".rd_pulse"}, 64'(rd_pulse), 64'(vecs[k].rd_pls));
            if (vecs[k].rd) check({vecs[k].name, ".rd_data"}, 64'(int_rd_data), 64'(vecs[k].rd_data));
            check({vecs[k].name, ".slot"}, 64'(ctrl_regs[vecs[k].slot*DW +: DW]), 64'(vecs[k].slot_val));
            @(negedge clk);
            check({vecs[k].name, ".ack_drop"}, 64'({int_wr_ack, int_rd_ack, wr_pulse, rd_pulse}), 64'h0);
        end

        // Write slot 3 then read it on the very next cycle.
        int_wr_en = 1'b1; int_addr = 10'h00C; int_wr_data = 32'h55AA55AA; int_wr_strb = 4'hF;
        @(negedge clk);
        check("b2b.wr_ack", 64'(int_wr_ack), 64'h1);
        check("b2b.slot3",  64'(ctrl_regs[3*DW +: DW]), 64'h55AA55AA);
        idle_inputs();
        int_rd_en = 1'b1; int_addr = 10'h00C;
        @(negedge clk);
        idle_inputs();
        check("b2b.rd_ack",  64'(int_rd_ack), 64'h1);
        check("b2b.wr_ack0", 64'(int_wr_ack), 64'h0);
        check("b2b.rd_data", 64'(int_rd_data), 64'h55AA55AA);
        check("b2b.rd_pls",  64'(rd_pulse), 64'h0008);
        repeat (3) @(negedge clk);
        check("b2b.rd_ack0", 64'(int_rd_ack), 64'h0);
        check("rd_data_hold", 64'(int_rd_data), 64'h55AA55AA);

        // Reset coinciding with a write: request is discarded, no ack.
        areset = 1'b1;
        int_wr_en = 1'b1; int_addr = 10'h000; int_wr_data = 32'hFFFFFFFF; int_wr_strb = 4'hF;
        @(negedge clk);
        areset = 1'b0;
        idle_inputs();
        check("rstwr.ack",   64'(int_wr_ack), 64'h0);
        check("rstwr.slot0", 64'(ctrl_regs[31:0]), 64'h12345678);
        check("rstwr.slot3", 64'(ctrl_regs[3*DW +: DW]), 64'h0);
        @(negedge clk);
        check("rstwr.ack2",  64'(int_wr_ack), 64'h0);
        check("rstwr.pls",   64'(wr_pulse), 64'h0);
        check("rstwr.rdat",  64'(int_rd_data), 64'h0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
